// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a two-entry skid buffer, bubble insertion,
// flush, and saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              bubble,
  output logic              bubble_ack,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  logic              main_vld_q, main_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  state_e            state;
  logic              fire_out;
  logic              src_take;
  logic [CTRL_W-1:0] src_ctrl;
  logic [DATA_W-1:0] src_data;

  // State is implied by which entries hold valid data.
  always_comb begin
    state = ST_EMPTY;
    if (main_vld_q) begin
      state = skid_vld_q ? ST_SKID : ST_FULL;
    end
  end

  // in_ready looks only at registered state, so out_ready never reaches upstream.
  assign in_ready   = !rst && (state != ST_SKID) && !bubble;
  assign bubble_ack = !rst && bubble && (state != ST_SKID) && !flush;
  assign fire_out   = main_vld_q && out_ready;
  assign src_take   = (in_valid && in_ready) || bubble_ack;
  assign src_ctrl   = bubble_ack ? '0 : in_ctrl;
  assign src_data   = bubble_ack ? '0 : in_data;

  always_comb begin
    main_vld_d  = main_vld_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_vld_d  = skid_vld_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      main_vld_d  = 1'b0;
      main_ctrl_d = '0;
      main_data_d = '0;
      skid_vld_d  = 1'b0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (src_take) begin
            main_vld_d  = 1'b1;
            main_ctrl_d = src_ctrl;
            main_data_d = src_data;
          end
        end
        ST_FULL: begin
          if (src_take && fire_out) begin
            main_ctrl_d = src_ctrl;
            main_data_d = src_data;
          end else if (src_take) begin
            skid_vld_d  = 1'b1;
            skid_ctrl_d = src_ctrl;
            skid_data_d = src_data;
          end else if (fire_out) begin
            main_vld_d  = 1'b0;
            main_ctrl_d = '0;
            main_data_d = '0;
          end
        end
        ST_SKID: begin
          if (fire_out) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_vld_d  = 1'b0;
            skid_ctrl_d = '0;
            skid_data_d = '0;
          end
        end
        default: begin
          main_vld_d = main_vld_q;
        end
      endcase
    end
  end

  // Saturating counters; flush leaves them alone.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_vld_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (bubble_ack && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q   <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_vld_q   <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      main_vld_q   <= main_vld_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_vld_q   <= skid_vld_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid  = main_vld_q;
  assign out_ctrl   = main_ctrl_q;
  assign out_data   = main_data_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the reference is a plain two-deep FIFO
// of held entries; a default instance and a CNT_W=2 instance share stimulus.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [8:0]   in_ctrl = '0;
  logic [127:0] in_data = '0;
  logic         bubble = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b1;

  logic         in_ready, bubble_ack, out_valid;
  logic [8:0]   out_ctrl;
  logic [127:0] out_data;
  logic [15:0]  stall_cnt, bubble_cnt;

  logic         in_ready_s, bubble_ack_s, out_valid_s;
  logic [8:0]   out_ctrl_s;
  logic [127:0] out_data_s;
  logic [1:0]   stall_cnt_s, bubble_cnt_s;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .bubble(bubble), .bubble_ack(bubble_ack), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.CTRL_W(9), .DATA_W(128), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_ctrl(in_ctrl), .in_data(in_data),
    .bubble(bubble), .bubble_ack(bubble_ack_s), .flush(flush),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_ctrl(out_ctrl_s), .out_data(out_data_s),
    .stall_cnt(stall_cnt_s), .bubble_cnt(bubble_cnt_s)
  );

  typedef struct {
    logic [8:0]   c;
    logic [127:0] d;
  } ent_t;

  ent_t exp_q[$];
  int   occ = 0;
  int   raw_stall = 0;
  int   raw_bub = 0;
  int   vectors = 0;
  int   checks = 0;
  int   errs = 0;
  logic last_take = 1'b0;
  logic last_ack = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Monitor: whatever the DUT presents must be the oldest entry the model holds.
  always @(negedge clk) begin
    if (exp_q.size() == 0) begin
      chk("out_valid_idle", 128'(out_valid), 128'(0));
      chk("out_ctrl_idle", 128'(out_ctrl), 128'(0));
      chk("out_data_idle", out_data, 128'(0));
      chk("sat_out_valid_idle", 128'(out_valid_s), 128'(0));
    end else begin
      chk("out_valid", 128'(out_valid), 128'(1));
      chk("out_ctrl", 128'(out_ctrl), 128'(exp_q[0].c));
      chk("out_data", out_data, exp_q[0].d);
      chk("sat_out_valid", 128'(out_valid_s), 128'(1));
      chk("sat_out_data", out_data_s, exp_q[0].d);
      chk("sat_out_ctrl", 128'(out_ctrl_s), 128'(exp_q[0].c));
      if (out_ready) void'(exp_q.pop_front());
    end
  end

  // One clock: drive inputs, check handshake/counters mid-cycle, advance the model.
  task automatic cycle(input logic r, input logic iv, input logic [8:0] c,
                       input logic [127:0] d, input logic b, input logic f,
                       input logic o);
    logic rdy_m, ack_m, fire, take;
    rst = r; in_valid = iv; in_ctrl = c; in_data = d;
    bubble = b; flush = f; out_ready = o;
    @(negedge clk);
    #1;
    vectors++;
    rdy_m = !r && (occ < 2) && !b;
    ack_m = !r && b && (occ < 2) && !f;
    chk("in_ready", 128'(in_ready), 128'(rdy_m));
    chk("bubble_ack", 128'(bubble_ack), 128'(ack_m));
    chk("sat_in_ready", 128'(in_ready_s), 128'(rdy_m));
    chk("sat_bubble_ack", 128'(bubble_ack_s), 128'(ack_m));
    chk("stall_cnt", 128'(stall_cnt), 128'(sat(raw_stall, 65535)));
    chk("bubble_cnt", 128'(bubble_cnt), 128'(sat(raw_bub, 65535)));
    chk("sat_stall_cnt", 128'(stall_cnt_s), 128'(sat(raw_stall, 3)));
    chk("sat_bubble_cnt", 128'(bubble_cnt_s), 128'(sat(raw_bub, 3)));
    fire = (occ > 0) && o;
    take = (iv && rdy_m) || ack_m;
    if (r) begin
      occ = 0; exp_q.delete(); raw_stall = 0; raw_bub = 0;
    end else begin
      if (occ > 0 && !o) raw_stall++;
      if (ack_m) raw_bub++;
      if (f) begin
        occ = 0; exp_q.delete();
      end else begin
        occ = occ - (fire ? 1 : 0) + (take ? 1 : 0);
        if (take) exp_q.push_back(ack_m ? ent_t'{9'd0, 128'd0} : ent_t'{c, d});
      end
    end
    last_take = take && !f && !r;
    last_ack = ack_m;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic o);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 9'd0, 128'd0, 1'b0, 1'b0, o);
  endtask

  initial begin
    int nxt;
    logic bh;
    // Reset then stream 1..4 at full rate.
    cycle(1'b1, 1'b0, 9'd0, 128'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 9'd0, 128'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 9'(i), 128'(i), 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Downstream stall with held offers until accepted.
    nxt = 1;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, nxt <= 4, 9'(nxt), 128'(nxt + 16), 1'b0, 1'b0, !(k >= 1 && k <= 4));
      if (last_take) nxt++;
    end
    idle(2, 1'b1);

    // Load-use bubble between A and B.
    cycle(1'b0, 1'b1, 9'h1A, 128'hA, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 9'h1B, 128'hB, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 9'h1B, 128'hB, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Bubble requested while the skid is full.
    cycle(1'b0, 1'b1, 9'h05, 128'h55, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 9'h06, 128'h66, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b0, 9'd0, 128'd0, 1'b1, 1'b0, k >= 3);
      if (last_ack) break;
    end
    idle(4, 1'b1);

    // Flush with both entries full plus a concurrent offer.
    cycle(1'b0, 1'b1, 9'h07, 128'h77, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 9'h08, 128'h88, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 9'h09, 128'h99, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    cycle(1'b0, 1'b1, 9'h0A, 128'hAA, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 9'h0B, 128'hBB, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Long stall saturates the narrow counters, then reset mid-stream.
    cycle(1'b0, 1'b1, 9'h0C, 128'hCC, 1'b0, 1'b0, 1'b0);
    idle(6, 1'b0);
    cycle(1'b0, 1'b1, 9'h0D, 128'hDD, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 9'h0E, 128'hEE, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Randomised traffic; a bubble request is held until acknowledged.
    bh = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      logic r, iv, f, o;
      r  = ($urandom_range(0, 255) == 0);
      iv = ($urandom_range(0, 9) < 7);
      f  = ($urandom_range(0, 15) == 0);
      o  = ($urandom_range(0, 9) < 7);
      if (!bh) bh = ($urandom_range(0, 7) == 0);
      cycle(r, iv, 9'($urandom), {$urandom, $urandom, $urandom, $urandom}, bh, f, o);
      if (last_ack) bh = 1'b0;
    end
    idle(4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
